// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle for the CPU/VGA clock step controller.
// The master side selects mode, rate and drives the raw step button;
// the slave side (the controller) returns the generated clocks and status.
interface clk_step_ctrl_if;
    logic [1:0]  mode;
    logic [1:0]  div_sel;
    logic        step_btn;
    logic        cpu_clk;
    logic        cpu_tick;
    logic        vga_clk;
    logic        halted;
    logic [31:0] cycle_cnt;

    modport master (
        output mode,
        output div_sel,
        output step_btn,
        input  cpu_clk,
        input  cpu_tick,
        input  vga_clk,
        input  halted,
        input  cycle_cnt
    );

    modport slave (
        input  mode,
        input  div_sel,
        input  step_btn,
        output cpu_clk,
        output cpu_tick,
        output vga_clk,
        output halted,
        output cycle_cnt
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock generator with RUN/HALT/STEP debug modes, runtime rate select,
// debounced single-step push button, free-running VGA clock and a count of
// CPU clock rising edges for the front-panel display.
module clk_step_ctrl #(
    parameter int CNT_W           = 26,
    parameter int CPU_DIV_DEFAULT = 24,
    parameter int VGA_DIV         = 1,
    parameter int DEB_CYCLES      = 16
) (
    input  logic          clk,
    input  logic          rst,
    clk_step_ctrl_if.slave bus
);

    // Half-period arithmetic is done 3 bits wider so div_sel=3 cannot wrap.
    localparam int HW    = CNT_W + 3;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int VGA_W = (VGA_DIV > 1) ? $clog2(VGA_DIV) : 1;
    localparam logic [HW-1:0] BASE_DIV = HW'(CPU_DIV_DEFAULT);

    typedef enum logic [1:0] {
        IDLE_LOW = 2'd0,
        LOW_PH   = 2'd1,
        HIGH_PH  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  h_reg, h_next;
    logic [HW-1:0]     h_wide;
    logic [CNT_W-1:0]  h_now;
    logic              boundary;
    logic              mode_run;
    logic              mode_step;

    logic              cpu_clk_reg, cpu_clk_next;
    logic              cpu_tick_reg, cpu_tick_next;
    logic              halted_reg, halted_next;
    logic [31:0]       cycle_cnt_reg;

    logic [1:0]        sync_reg, sync_next;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic              acc_reg;
    logic              acc_d_reg;
    logic              step_req;
    logic              pending_reg;
    logic              consume;

    logic [VGA_W-1:0]  vga_cnt_reg;
    logic              vga_clk_reg;

    // Mode 11 is an alias of RUN; HALT needs no explicit decode because it
    // is simply "neither run nor step".
    assign mode_run  = (bus.mode == 2'b00) || (bus.mode == 2'b11);
    assign mode_step = (bus.mode == 2'b10);

    // Live half-period from div_sel, clamped to [1, 2^CNT_W-1].
    always_comb begin
        h_wide = BASE_DIV << bus.div_sel;
        if (h_wide == '0) begin
            h_now = CNT_W'(1);
        end else if (h_wide[HW-1:CNT_W] != '0) begin
            h_now = '1;
        end else begin
            h_now = h_wide[CNT_W-1:0];
        end
    end

    // Last cycle of the current phase; only here may rate or mode take effect.
    assign boundary = (cnt_reg == (h_reg - CNT_W'(1)));

    // ------------------------------------------------------------------
    // Step button: two-stage synchroniser, debounce, rising-edge detect.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_next[gi] = bus.step_btn;
        end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
        end
    end

    // Synchroniser chain for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // Accept a new button level only after DEB_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_reg <= '0;
            acc_reg     <= 1'b0;
            acc_d_reg   <= 1'b0;
        end else begin
            acc_d_reg <= acc_reg;
            if (sync_reg[1] == acc_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                acc_reg     <= sync_reg[1];
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    assign step_req = acc_reg & ~acc_d_reg;

    // Single-entry step request latch; a new request while one is held is lost,
    // but a request arriving in the consume cycle replaces the consumed one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_reg <= 1'b0;
        end else if (step_req) begin
            pending_reg <= 1'b1;
        end else if (consume) begin
            pending_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // CPU clock phase FSM.
    // ------------------------------------------------------------------

    // State, phase counter and latched half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE_LOW;
            cnt_reg   <= '0;
            h_reg     <= CNT_W'(1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            h_reg     <= h_next;
        end
    end

    // Next state: the idle cycle that launches a phase already counts as low
    // cycle 0, so the first rise lands H edges after the launch decision.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        h_next     = h_reg;
        consume    = 1'b0;
        case (state_reg)
            IDLE_LOW: begin
                cnt_next = '0;
                if (mode_run || (mode_step && pending_reg)) begin
                    consume = mode_step;
                    h_next  = h_now;
                    if (h_now == CNT_W'(1)) begin
                        state_next = HIGH_PH;
                    end else begin
                        state_next = LOW_PH;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            LOW_PH: begin
                if (boundary) begin
                    state_next = HIGH_PH;
                    cnt_next   = '0;
                    h_next     = h_now;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HIGH_PH: begin
                if (boundary) begin
                    state_next = mode_run ? LOW_PH : IDLE_LOW;
                    cnt_next   = '0;
                    h_next     = h_now;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a clean register.
    always_comb begin
        cpu_clk_next  = (state_next == HIGH_PH);
        cpu_tick_next = (state_next == HIGH_PH) && (state_reg != HIGH_PH);
        halted_next   = (state_next == IDLE_LOW);
    end

    // Registered CPU-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_clk_reg  <= 1'b0;
            cpu_tick_reg <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            cpu_clk_reg  <= cpu_clk_next;
            cpu_tick_reg <= cpu_tick_next;
            halted_reg   <= halted_next;
        end
    end

    // Rising-edge counter; updates on the same edge cpu_clk rises, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_reg <= '0;
        end else if (cpu_tick_next) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // VGA clock: independent free-running divider.
    // ------------------------------------------------------------------

    // Toggle vga_clk every VGA_DIV clk cycles regardless of CPU mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_cnt_reg <= '0;
            vga_clk_reg <= 1'b0;
        end else if (vga_cnt_reg == VGA_W'(VGA_DIV - 1)) begin
            vga_cnt_reg <= '0;
            vga_clk_reg <= ~vga_clk_reg;
        end else begin
            vga_cnt_reg <= vga_cnt_reg + VGA_W'(1);
        end
    end

    assign bus.cpu_clk   = cpu_clk_reg;
    assign bus.cpu_tick  = cpu_tick_reg;
    assign bus.vga_clk   = vga_clk_reg;
    assign bus.halted    = halted_reg;
    assign bus.cycle_cnt = cycle_cnt_reg;

endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Parametrised successor to the fixed CPU/VGA clock divider that sits between the board oscillator and FEPU/BEPU.
- Generates a divided cpu_clk with a runtime-selectable rate and RUN/HALT/STEP modes for single-cycle CPU debug from a push button.
- Generates a free-running vga_clk and a cpu-cycle counter for the LED/segment display.
- Lives in top_core in place of the plain divider.

Parameters:
CNT_W, 26, width of phase counter and half-period arithmetic
CPU_DIV_DEFAULT, 24, base cpu_clk half-period in clk cycles (div_sel=0)
VGA_DIV, 1, vga_clk half-period in clk cycles (>=1)
DEB_CYCLES, 16, consecutive stable synchronised samples required to accept a step_btn level change

Ports:
clk  in  1  board clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
mode  in  2  00 RUN, 01 HALT, 10 STEP, 11 RUN (same as 00)
div_sel  in  2  half-period = CPU_DIV_DEFAULT << div_sel
step_btn  in  1  raw asynchronous push button, active-high
cpu_clk  out  1  divided CPU clock, registered
cpu_tick  out  1  one-clk pulse in the cycle cpu_clk goes 0->1
vga_clk  out  1  free-running divided clock, registered
halted  out  1  1 when cpu_clk is low and no phase is being generated
cycle_cnt  out  32  number of cpu_clk rising edges since reset

Behaviour:
- Reset (rst=0, asynchronous): cpu_clk=0, cpu_tick=0, vga_clk=0, halted=0, cycle_cnt=0, phase counter=0, state=IDLE_LOW, step pending=0, synchroniser and debounce state cleared. Outputs stay at these values while rst=0, including when reset is asserted mid-phase.
- Half-period H:
  - Computed as CPU_DIV_DEFAULT<<div_sel in CNT_W+3 bits.
  - Result 0 is clamped to 1; result above 2^CNT_W-1 saturates to all-ones.
  - H and the effective mode are sampled only at a phase boundary: the cycle the counter reaches H-1, or on entry to LOW_PH from IDLE_LOW. No runt pulses are permitted.
- Phase counter: counts 0..H-1, then returns to 0 and cpu_clk toggles on the same edge. Full period is therefore 2H clk cycles.
- States:
  - IDLE_LOW: cpu_clk=0, counter held at 0, halted=1 (except in the first cycle after reset, where halted=0).
    - mode RUN -> LOW_PH.
    - mode STEP with pending=1 -> LOW_PH, and pending is cleared.
  - LOW_PH: cpu_clk=0; after H cycles cpu_clk->1, cpu_tick=1 for one cycle, cycle_cnt+1 -> HIGH_PH.
  - HIGH_PH: cpu_clk=1; after H cycles cpu_clk->0, then:
    - mode RUN -> LOW_PH.
    - mode HALT or STEP -> IDLE_LOW.
  - A mode change during HIGH_PH never truncates the high phase.
  - HALT entered during LOW_PH completes that low phase and the following high phase, then idles.
- Step path:
  - step_btn is synchronised by 2 flip-flops, then debounced: the accepted level changes only after DEB_CYCLES identical samples.
  - A rising edge of the accepted level sets pending.
  - pending holds at most one request. Requests while pending=1 are dropped.
  - Requests in RUN or HALT set pending, which is consumed on the next STEP-mode idle.
- cycle_cnt: increments by 1 per cpu_tick and wraps 0xFFFFFFFF->0.
- vga_clk: toggles every VGA_DIV clk cycles in all modes. Its counter is independent of the cpu path.
- Latency from first clk edge after reset release (RUN): first cpu_tick and cpu_clk rise at edge H. The step-to-rise latency is 2 (sync) + DEB_CYCLES + 1 (edge) + 1 (pending->LOW_PH) + H cycles.

Test Plan:
- Bench overrides: CPU_DIV_DEFAULT=3, VGA_DIV=1, DEB_CYCLES=4.
- Reset release, mode=00, div_sel=0 -> cpu_clk rises at edge 3, period 6; cpu_tick high exactly 1 cycle per period; cycle_cnt=10 after 60 clks; vga_clk period 2.
- div_sel 0->2 changed mid high phase -> current phase completes at 3 cycles; subsequent half-periods are 12; no pulse shorter than 3 cycles.
- mode=10, step_btn pulses 2 cycles (glitch) -> no cpu_tick. Step_btn held 10 cycles -> exactly one cpu_clk pulse of 3 high cycles, then halted=1 and cycle_cnt+1.
- mode=10, two debounced presses during one pulse -> exactly two pulses total (one pending); a third press during the same pulse is dropped.
- mode RUN -> HALT during low phase -> one more full high phase, then cpu_clk=0 and halted=1 indefinitely; vga_clk keeps toggling.
- Force cycle_cnt to 0xFFFFFFFF, then one tick -> 0. rst=0 asserted mid high phase -> cpu_clk=0 and all outputs at reset values without a clk edge.
